spart_driver: RTL and testbench
===============================

SPART_DRIVER -- requirements
Module: spart_driver

Interface
REQ-001 Parameter DIV_4800, default 16'd1301; divisor loaded when br_cfg=2'b00.
REQ-002 Parameter DIV_9600, default 16'd650; divisor for br_cfg=2'b01.
REQ-003 Parameter DIV_19200, default 16'd324; divisor for br_cfg=2'b10.
REQ-004 Parameter DIV_38400, default 16'd162; divisor for br_cfg=2'b11.
REQ-005 Port clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port br_cfg  input  2  baud select; assumed static except for deliberate reconfiguration.
REQ-008 Port rda  input  1  receive-data-available from the SPART.
REQ-009 Port tbr  input  1  transmit-buffer-ready from the SPART.
REQ-010 Port iocs  output  1  SPART chip select.
REQ-011 Port iorw  output  1  1 = read from SPART, 0 = write to SPART.
REQ-012 Port ioaddr  output  2  00 = data buffer, 01 = status, 10 = divisor low, 11 = divisor high.
REQ-013 Port databus  inout  8  shared SPART data bus.
REQ-014 Port echo_count  output  4  current echo-FIFO occupancy, 0..8.

Function
REQ-015 The block SHALL use FSM states CFG_LO, CFG_HI, IDLE, RD, WR and GAP.
REQ-016 CFG_LO SHALL drive iocs=1, iorw=0, ioaddr=10 and divisor[7:0] for exactly one cycle, then go to CFG_HI.
REQ-017 CFG_HI SHALL drive iocs=1, iorw=0, ioaddr=11 and divisor[15:0]'s upper byte for one cycle, then go to GAP; low is always written before high.
REQ-018 The divisor SHALL be selected combinationally from br_cfg through the four parameters.
REQ-019 br_cfg SHALL be registered each cycle; any change seen in IDLE or GAP SHALL force the next state to CFG_LO, with the FIFO contents kept.
REQ-020 In IDLE, if rda=1 and the FIFO is not full, the next state SHALL be RD.
REQ-021 Otherwise in IDLE, if tbr=1 and the FIFO is not empty, the next state SHALL be WR.
REQ-022 If both RD and WR conditions hold, RD SHALL win, so receive is never starved.
REQ-023 RD SHALL drive iocs=1, iorw=1, ioaddr=00 for one cycle and push the databus value into the FIFO at the end of that cycle.
REQ-024 WR SHALL drive iocs=1, iorw=0, ioaddr=00 with the FIFO head on databus for one cycle and pop the FIFO at the end of that cycle.
REQ-025 RD and WR SHALL always be followed by one GAP cycle (iocs=0) so the SPART's registered rda/tbr can update; GAP then returns to IDLE.
REQ-026 databus SHALL be driven only when iocs=1 and iorw=0, and SHALL be high-Z otherwise.
REQ-027 Outside CFG_LO, CFG_HI, RD and WR, the outputs SHALL be iocs=0, iorw=1, ioaddr=00.
REQ-028 The FIFO SHALL be 8 deep by 8 bits with 3-bit wrapping read/write pointers and a 4-bit count.
REQ-029 Full SHALL mean count==8 and empty SHALL mean count==0; push and pop never occur in the same cycle.
REQ-030 With the FIFO full, rda=1 SHALL leave the byte in the SPART, applying back-pressure with no loss and no overwrite.
REQ-031 Bytes SHALL be echoed in arrival order.

Reset
REQ-032 While rst=0 the block SHALL hold state CFG_LO, pointers=0, echo_count=0, iocs=0, iorw=1, ioaddr=00 and databus high-Z.
REQ-033 On rst release, divisor programming SHALL begin on the first clock edge.
REQ-034 Reset asserted mid-access SHALL abort the access immediately (asynchronously) and discard the FIFO contents.

Structure
REQ-035 A shared package spart_pkg SHALL hold the ioaddr encodings (ADDR_DATA, ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI), the FSM state type and the default divisor constants.
REQ-036 The FIFO SHALL be a separate sub-module named echo_fifo (push, pop, din, dout, full, empty, count) instantiated once.

Verification
REQ-037 Reset release with br_cfg=01: iocs=1 with ioaddr=10 and databus=8'h8A, next cycle ioaddr=11 and databus=8'h02, then a GAP cycle with iocs=0.
REQ-038 With a SPART model, deliver 8'h41 on rxd: one RD cycle, echo_count=1, then a WR cycle with databus=8'h41, echo_count=0, and 8'h41 appears on txd.
REQ-039 tbr held 0 while 9 bytes arrive: 8 RD accesses, echo_count=8, and the 9th byte is not read until after tbr=1 and one WR.
REQ-040 rda=1 and tbr=1 in the same IDLE cycle with a non-empty FIFO: the sequence is RD, GAP, IDLE, WR.
REQ-041 br_cfg changed 10->11 in IDLE: the next accesses are CFG_LO with databus=8'hA2, then CFG_HI with databus=8'h00, and echo_count is unchanged.
REQ-042 rst pulsed low during WR: databus goes high-Z asynchronously, echo_count=0, and reprogramming restarts in CFG_LO.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART echo driver: bus address map, FSM states and
// default baud divisors.
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam logic [15:0] DEF_DIV_4800  = 16'd1301;
    localparam logic [15:0] DEF_DIV_9600  = 16'd650;
    localparam logic [15:0] DEF_DIV_19200 = 16'd324;
    localparam logic [15:0] DEF_DIV_38400 = 16'd162;

    localparam int unsigned FIFO_DEPTH = 8;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        WR,
        GAP
    } state_t;

    function automatic logic [15:0] sel_divisor(
        input logic [1:0]  cfg,
        input logic [15:0] d0,
        input logic [15:0] d1,
        input logic [15:0] d2,
        input logic [15:0] d3
    );
        logic [15:0] w_div;
        case (cfg)
            2'b00:   w_div = d0;
            2'b01:   w_div = d1;
            2'b10:   w_div = d2;
            default: w_div = d3;
        endcase
        return w_div;
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// 8-deep by 8-bit FIFO holding received bytes until they can be echoed back.
module echo_fifo
    import spart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    logic [7:0] r_mem [FIFO_DEPTH];
    logic [2:0] r_wr_ptr;
    logic [2:0] r_rd_ptr;
    logic [3:0] r_count;
    logic       w_wr_en;
    logic       w_rd_en;

    assign full    = (r_count == 4'(FIFO_DEPTH));
    assign empty   = (r_count == 4'd0);
    assign count   = r_count;
    assign dout    = r_mem[r_rd_ptr];
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_count  <= 4'd0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 3'd1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 3'd1;
            end
            // The driver never pushes and pops in the same cycle.
            if (w_wr_en) begin
                r_count <= r_count + 4'd1;
            end else if (w_rd_en) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/spart_driver.sv
// SPART echo driver: programs the baud divisor, then reads received bytes into a
// FIFO and writes them back out in arrival order.
module spart_driver
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_4800  = DEF_DIV_4800,
    parameter logic [15:0] DIV_9600  = DEF_DIV_9600,
    parameter logic [15:0] DIV_19200 = DEF_DIV_19200,
    parameter logic [15:0] DIV_38400 = DEF_DIV_38400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic [3:0] echo_count
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_br_cfg;
    logic        r_cfg_dirty;
    logic        w_reprog;
    logic [15:0] w_divisor;
    logic        w_full;
    logic        w_empty;
    logic [7:0]  w_fifo_dout;
    logic        w_push;
    logic        w_pop;
    logic        w_iocs;
    logic        w_iorw;
    logic [1:0]  w_ioaddr;
    logic [7:0]  w_wdata;

    assign w_divisor = sel_divisor(br_cfg, DIV_4800, DIV_9600, DIV_19200, DIV_38400);

    // A baud change seen mid-access is remembered until the next IDLE/GAP.
    assign w_reprog = r_cfg_dirty || (br_cfg != r_br_cfg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= CFG_LO;
            r_br_cfg    <= 2'b00;
            r_cfg_dirty <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_br_cfg    <= br_cfg;
            r_cfg_dirty <= (r_state == CFG_LO) ? 1'b0 : w_reprog;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CFG_LO: w_next = CFG_HI;
            CFG_HI: w_next = GAP;
            IDLE: begin
                if (w_reprog) begin
                    w_next = CFG_LO;
                end else if (rda && !w_full) begin
                    w_next = RD;
                end else if (tbr && !w_empty) begin
                    w_next = WR;
                end
            end
            RD:      w_next = GAP;
            WR:      w_next = GAP;
            GAP:     w_next = w_reprog ? CFG_LO : IDLE;
            default: w_next = CFG_LO;
        endcase
    end

    always_comb begin
        w_iocs   = 1'b0;
        w_iorw   = 1'b1;
        w_ioaddr = ADDR_DATA;
        w_wdata  = 8'h00;
        case (r_state)
            CFG_LO: begin
                w_iocs   = 1'b1;
                w_iorw   = 1'b0;
                w_ioaddr = ADDR_DB_LO;
                w_wdata  = w_divisor[7:0];
            end
            CFG_HI: begin
                w_iocs   = 1'b1;
                w_iorw   = 1'b0;
                w_ioaddr = ADDR_DB_HI;
                w_wdata  = w_divisor[15:8];
            end
            RD: begin
                w_iocs = 1'b1;
            end
            WR: begin
                w_iocs  = 1'b1;
                w_iorw  = 1'b0;
                w_wdata = w_fifo_dout;
            end
            default: ;
        endcase
    end

    // Reset gates the bus immediately rather than waiting for a clock edge.
    assign iocs    = rst && w_iocs;
    assign iorw    = w_iorw || !rst;
    assign ioaddr  = rst ? w_ioaddr : ADDR_DATA;
    assign databus = (iocs && !iorw) ? w_wdata : 8'hzz;

    assign w_push = (r_state == RD);
    assign w_pop  = (r_state == WR);

    echo_fifo u_echo_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (databus),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (echo_count)
    );

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: behavioural SPART model with an arrival-order reference queue.
module tb_spart_driver;

    localparam int K_NONE = 0;
    localparam int K_LO   = 1;
    localparam int K_HI   = 2;
    localparam int K_RD   = 3;
    localparam int K_WR   = 4;
    localparam int K_OTH  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b01;
    logic       rda = 1'b0;
    logic       tbr = 1'b0;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [3:0] echo_count;
    logic [7:0] spart_rd_data = 8'h00;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rxq [$];
    logic [7:0] expq [$];
    logic [7:0] txq [$];
    int         model_cnt = 0;
    bit         tbr_en = 1'b0;
    int         last_kind = K_NONE;
    logic [7:0] last_data = 8'h00;

    always #5 clk = ~clk;

    // SPART answers data reads from its receive queue.
    assign databus = (iocs && iorw && ioaddr == 2'b00) ? spart_rd_data : 8'hzz;

    spart_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .rda        (rda),
        .tbr        (tbr),
        .iocs       (iocs),
        .iorw       (iorw),
        .ioaddr     (ioaddr),
        .databus    (databus),
        .echo_count (echo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int classify();
        if (!iocs) return K_NONE;
        if (iorw && ioaddr == 2'b00) return K_RD;
        if (!iorw && ioaddr == 2'b00) return K_WR;
        if (!iorw && ioaddr == 2'b10) return K_LO;
        if (!iorw && ioaddr == 2'b11) return K_HI;
        return K_OTH;
    endfunction

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        expq.push_back(b);
        rda = 1'b1;
        spart_rd_data = rxq[0];
    endtask

    // Observe the current cycle, let the edge complete it, then update the SPART model.
    task automatic step();
        int k;
        logic [7:0] d;
        k = classify();
        d = databus;
        @(posedge clk);
        #1;
        last_kind = k;
        last_data = d;
        if (k == K_RD) begin
            check("rd_when_not_full", 32'(model_cnt < 8), 1);
            if (rxq.size() > 0) void'(rxq.pop_front());
            model_cnt++;
        end else if (k == K_WR) begin
            if (expq.size() > 0) check("echo_order", d, expq.pop_front());
            else check("wr_with_nothing_pending", 1, 0);
            txq.push_back(d);
            model_cnt--;
        end
        if (rst) check("echo_count", echo_count, model_cnt);
        rda = (rxq.size() != 0);
        tbr = tbr_en;
        spart_rd_data = rda ? rxq[0] : 8'h00;
        #1;
    endtask

    task automatic wait_kind(input int kind, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (last_kind == kind) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    task automatic next_access(input int budget, output int kind);
        kind = K_NONE;
        for (int i = 0; i < budget && kind == K_NONE; i++) begin
            step();
            kind = last_kind;
        end
    endtask

    task automatic drain(input int budget, input string tag);
        for (int i = 0; i < budget && (model_cnt != 0 || rxq.size() != 0); i++) step();
        check(tag, 32'(model_cnt == 0 && rxq.size() == 0), 1);
    endtask

    initial begin
        int n_rd;
        int extra;
        int k;
        int kinds [5];

        // Reset state
        #3;
        check("rst_iocs", iocs, 0);
        check("rst_iorw", iorw, 1);
        check("rst_ioaddr", ioaddr, 2'b00);
        check("rst_bus_released", 32'(iocs && !iorw), 0);
        check("rst_count", echo_count, 0);
        step();
        step();
        check("rst_hold_iocs", iocs, 0);

        // Reset release programs divisor 650 = 0x028A
        rst = 1'b1;
        #1;
        check("cfg_lo_iocs", iocs, 1);
        check("cfg_lo_addr", ioaddr, 2'b10);
        check("cfg_lo_data", databus, 8'h8A);
        step();
        check("cfg_hi_addr", ioaddr, 2'b11);
        check("cfg_hi_data", databus, 8'h02);
        step();
        check("cfg_gap_iocs", iocs, 0);
        step();

        // Single echo of 0x41
        tbr_en = 1'b1;
        tbr = 1'b1;
        push_rx(8'h41);
        wait_kind(K_RD, 10, "rx41_read");
        check("rx41_count", echo_count, 1);
        wait_kind(K_WR, 10, "rx41_write");
        check("rx41_wdata", last_data, 8'h41);
        check("rx41_count_after", echo_count, 0);
        check("rx41_txd", 32'(txq.size() == 1 && txq[0] == 8'h41), 1);

        // Back-pressure: nine bytes with tbr low
        tbr_en = 1'b0;
        tbr = 1'b0;
        for (int i = 0; i < 9; i++) push_rx(8'($urandom));
        n_rd = 0;
        for (int i = 0; i < 200 && n_rd < 8; i++) begin
            step();
            if (last_kind == K_RD) n_rd++;
        end
        check("bp_reads", n_rd, 8);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_kind == K_RD) extra++;
        end
        check("bp_no_ninth_read", extra, 0);
        check("bp_full_count", echo_count, 8);
        check("bp_byte_held", rxq.size(), 1);
        tbr_en = 1'b1;
        tbr = 1'b1;
        next_access(20, k);
        check("bp_first_wr", k, K_WR);
        next_access(20, k);
        check("bp_then_rd", k, K_RD);
        drain(300, "bp_drain");

        // Simultaneous rda/tbr with non-empty FIFO: RD wins
        tbr_en = 1'b0;
        tbr = 1'b0;
        push_rx(8'($urandom));
        wait_kind(K_RD, 10, "prio_fill");
        for (int i = 0; i < 3; i++) step();
        push_rx(8'($urandom));
        tbr_en = 1'b1;
        tbr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            kinds[i] = last_kind;
        end
        check("prio_idle", kinds[0], K_NONE);
        check("prio_rd", kinds[1], K_RD);
        check("prio_gap", kinds[2], K_NONE);
        check("prio_idle2", kinds[3], K_NONE);
        check("prio_wr", kinds[4], K_WR);
        drain(100, "prio_drain");

        // Baud reconfiguration: 324 = 0x0144, then 162 = 0x00A2
        tbr_en = 1'b0;
        tbr = 1'b0;
        for (int i = 0; i < 3; i++) step();
        br_cfg = 2'b10;
        wait_kind(K_LO, 6, "br10_lo");
        check("br10_lo_data", last_data, 8'h44);
        step();
        check("br10_hi", last_kind, K_HI);
        check("br10_hi_data", last_data, 8'h01);
        push_rx(8'($urandom));
        wait_kind(K_RD, 10, "br_fill");
        step();
        step();
        br_cfg = 2'b11;
        wait_kind(K_LO, 6, "br11_lo");
        check("br11_lo_data", last_data, 8'hA2);
        step();
        check("br11_hi", last_kind, K_HI);
        check("br11_hi_data", last_data, 8'h00);
        check("br11_count_kept", echo_count, 1);

        // Reset pulse mid-WR
        push_rx(8'($urandom));
        push_rx(8'($urandom));
        for (int i = 0; i < 40 && rxq.size() != 0; i++) step();
        tbr_en = 1'b1;
        tbr = 1'b1;
        k = K_NONE;
        for (int i = 0; i < 20 && k != K_WR; i++) begin
            step();
            k = classify();
        end
        check("rstwr_in_wr", k, K_WR);
        #2;
        rst = 1'b0;
        #1;
        check("rstwr_iocs", iocs, 0);
        check("rstwr_bus_released", 32'(iocs && !iorw), 0);
        check("rstwr_count", echo_count, 0);
        for (int i = 0; i < model_cnt; i++) void'(expq.pop_front());
        model_cnt = 0;
        tbr_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rstwr_cfg_lo_addr", ioaddr, 2'b10);
        check("rstwr_cfg_lo_data", databus, 8'hA2);
        step();
        step();
        check("rstwr_cfg_hi", last_kind, K_HI);

        // Random traffic with tbr toggling
        extra = 0;
        for (int i = 0; i < 400; i++) begin
            if (extra < 40 && $urandom_range(0, 3) == 0) begin
                push_rx(8'($urandom));
                extra++;
            end
            if ($urandom_range(0, 7) == 0) tbr_en = ~tbr_en;
            step();
        end
        tbr_en = 1'b1;
        drain(600, "rand_drain");
        check("rand_all_echoed", expq.size(), 0);
        check("rand_final_count", echo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
